// File: rtl/tt2e_pkg.sv
// Shared code assignments for the 2150 keyboard path: tilt/rotate codes, EBCDIC bytes, shift state, translation.
// TT2E_PARITY_EN widens each stored entry to carry an odd-parity bit.
package tt2e_pkg;

    localparam logic [5:0] SHIFT_UP   = 6'h3C;
    localparam logic [5:0] SHIFT_DOWN = 6'h3D;
    localparam logic [5:0] TT_NL      = 6'h3E;
    localparam logic [5:0] TT_SP      = 6'h3F;

    localparam logic [7:0] E_NL = 8'h15;
    localparam logic [7:0] E_SP = 8'h40;
    localparam logic [7:0] E_A  = 8'hC1;
    localparam logic [7:0] E_a  = 8'h81;
    localparam logic [7:0] E_0  = 8'hF0;

`ifdef TT2E_PARITY_EN
    localparam int ENTRY_W = 9;
`else
    localparam int ENTRY_W = 8;
`endif

    typedef enum logic {
        ST_LOWER = 1'b0,
        ST_UPPER = 1'b1
    } shift_e;

    typedef struct packed {
        logic       valid;
        logic [7:0] data;
    } xlat_t;

    // Codes 00-08 are letters a-i, 10-19 the digit row (symbols when shifted).
    function automatic xlat_t translate(input shift_e sh, input logic [5:0] code);
        xlat_t r;
        r.valid = 1'b1;
        r.data  = 8'h00;
        if (code <= 6'h08) begin
            r.data = (sh == ST_UPPER) ? (E_A + {2'b00, code}) : (E_a + {2'b00, code});
        end else if (code >= 6'h10 && code <= 6'h19) begin
            if (sh == ST_LOWER) begin
                r.data = E_0 + {4'h0, code[3:0]};
            end else begin
                case (code[3:0])
                    4'h0:    r.data = 8'h7E;
                    4'h1:    r.data = 8'h5A;
                    4'h2:    r.data = 8'h7C;
                    4'h3:    r.data = 8'h7B;
                    4'h4:    r.data = 8'h5B;
                    4'h5:    r.data = 8'h6C;
                    4'h6:    r.data = 8'h5F;
                    4'h7:    r.data = 8'h50;
                    4'h8:    r.data = 8'h5C;
                    default: r.data = 8'h4D;
                endcase
            end
        end else if (code == TT_NL) begin
            r.data = E_NL;
        end else if (code == TT_SP) begin
            r.data = E_SP;
        end else begin
            r.valid = 1'b0;
        end
        return r;
    endfunction

endpackage

// File: rtl/tt2e_if.sv
// Keyboard/channel-side signal bundle for tt2e; slave is the converter, master the surrounding logic.
// o_data_parity exists only when TT2E_PARITY_EN is defined.
interface tt2e_if;
    logic [5:0] i_kbd_code;
    logic       i_kbd_strobe;
    logic       i_rd;
    logic       i_clr_overrun;
    logic [7:0] o_data_reg;
    logic       o_data_valid;
    logic       o_upper_case_character;
    logic       o_lower_case_character;
    logic       o_overrun;
    logic       o_invalid;
`ifdef TT2E_PARITY_EN
    logic       o_data_parity;
`endif

    modport slave (
        input  i_kbd_code, i_kbd_strobe, i_rd, i_clr_overrun,
        output o_data_reg, o_data_valid, o_upper_case_character,
        output o_lower_case_character, o_overrun, o_invalid
`ifdef TT2E_PARITY_EN
        , output o_data_parity
`endif
    );

    modport master (
        output i_kbd_code, i_kbd_strobe, i_rd, i_clr_overrun,
        input  o_data_reg, o_data_valid, o_upper_case_character,
        input  o_lower_case_character, o_overrun, o_invalid
`ifdef TT2E_PARITY_EN
        , input o_data_parity
`endif
    );

endinterface

// File: rtl/tt2e_fifo.sv
// First-word-fall-through FIFO, 2**AW entries; a pop frees a slot for a push in the same cycle.
// Head reads as zero while empty so the data port has a defined value after reset.
module tt2e_fifo #(
    parameter int AW = 2,
    parameter int DW = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  logic [DW-1:0] wdata,
    input  logic          pop,
    output logic [DW-1:0] rdata,
    output logic          empty,
    output logic          full
);

    localparam int DEPTH = 1 << AW;

    logic [DW-1:0] mem_q [DEPTH];
    logic [DW-1:0] mem_d [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q, count_d;
    logic          do_push, do_pop;

    assign empty   = (count_q == '0);
    assign full    = (count_q == (AW+1)'(DEPTH));
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);
    assign rdata   = empty ? '0 : mem_q[rd_ptr_q];

    always_comb begin
        mem_d = mem_q;
        if (do_push) mem_d[wr_ptr_q] = wdata;
        wr_ptr_d = wr_ptr_q + AW'(do_push);
        rd_ptr_d = rd_ptr_q + AW'(do_pop);
        count_d  = count_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/tt2e.sv
// 2150 keyboard converter: shift tracking, tilt/rotate to EBCDIC translation, FWFT byte FIFO.
// Build option TT2E_PARITY_EN stores odd parity with each byte and drives o_data_parity.
module tt2e
    import tt2e_pkg::*;
#(
    parameter int FIFO_AW = 2
) (
    input  logic i_clk,
    input  logic i_reset,
    tt2e_if.slave bus
);

    shift_e               shift_q, shift_d;
    logic                 xl_valid_q, xl_valid_d;
    logic [ENTRY_W-1:0]   xl_data_q, xl_data_d;
    logic                 invalid_q, invalid_d;
    logic                 overrun_q, overrun_d;
    xlat_t                xl;
    logic [ENTRY_W-1:0]   fifo_rdata;
    logic                 fifo_empty, fifo_full, fifo_pop, drop;

    assign fifo_pop = bus.i_rd & ~fifo_empty;
    assign drop     = xl_valid_q & fifo_full & ~fifo_pop;

    always_comb begin
        shift_d    = shift_q;
        xl_valid_d = 1'b0;
        xl_data_d  = xl_data_q;
        invalid_d  = 1'b0;
        xl         = translate(shift_q, bus.i_kbd_code);
        if (bus.i_kbd_strobe) begin
            if (bus.i_kbd_code == SHIFT_UP) begin
                shift_d = ST_UPPER;
            end else if (bus.i_kbd_code == SHIFT_DOWN) begin
                shift_d = ST_LOWER;
            end else if (xl.valid) begin
                xl_valid_d = 1'b1;
`ifdef TT2E_PARITY_EN
                xl_data_d  = {~^xl.data, xl.data};
`else
                xl_data_d  = xl.data;
`endif
            end else begin
                invalid_d = 1'b1;
            end
        end
        // A drop wins over a simultaneous clear so no lost character goes unreported.
        overrun_d = drop | (overrun_q & ~bus.i_clr_overrun);
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            shift_q    <= ST_LOWER;
            xl_valid_q <= 1'b0;
            xl_data_q  <= '0;
            invalid_q  <= 1'b0;
            overrun_q  <= 1'b0;
        end else begin
            shift_q    <= shift_d;
            xl_valid_q <= xl_valid_d;
            xl_data_q  <= xl_data_d;
            invalid_q  <= invalid_d;
            overrun_q  <= overrun_d;
        end
    end

    tt2e_fifo #(
        .AW (FIFO_AW),
        .DW (ENTRY_W)
    ) u_fifo (
        .clk   (i_clk),
        .rst   (i_reset),
        .push  (xl_valid_q),
        .wdata (xl_data_q),
        .pop   (fifo_pop),
        .rdata (fifo_rdata),
        .empty (fifo_empty),
        .full  (fifo_full)
    );

    assign bus.o_data_reg             = fifo_rdata[7:0];
    assign bus.o_data_valid           = ~fifo_empty;
    assign bus.o_upper_case_character = (shift_q == ST_UPPER);
    assign bus.o_lower_case_character = (shift_q == ST_LOWER);
    assign bus.o_overrun              = overrun_q;
    assign bus.o_invalid              = invalid_q;
`ifdef TT2E_PARITY_EN
    assign bus.o_data_parity          = fifo_empty ? 1'b1 : fifo_rdata[8];
`endif

endmodule

// File: tb/tb_tt2e.sv
// Self-checking bench for tt2e: key table, directed corner sequences, then random traffic against a queue model.
module tb_tt2e;
    import tt2e_pkg::*;

    localparam int DEPTH = 4;
    localparam logic [7:0] UP_DIGIT [10] = '{8'h7E, 8'h5A, 8'h7C, 8'h7B, 8'h5B,
                                             8'h6C, 8'h5F, 8'h50, 8'h5C, 8'h4D};

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_chk = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;

    tt2e_if bus();
    tt2e #(.FIFO_AW(2)) dut (.i_clk(clk), .i_reset(rst), .bus(bus));

    typedef struct {
        logic       up;
        logic [5:0] code;
        logic       inv;
        logic [7:0] exp_byte;
    } vec_t;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic key(input logic [5:0] c);
        bus.i_kbd_code   = c;
        bus.i_kbd_strobe = 1'b1;
        tick();
        bus.i_kbd_strobe = 1'b0;
    endtask

    task automatic pop_expect(input string nm, input logic [7:0] b);
        chk({nm, "_valid"}, bus.o_data_valid, 1'b1);
        chk({nm, "_data"}, bus.o_data_reg, b);
        bus.i_rd = 1'b1;
        tick();
        bus.i_rd = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        tick();
    endtask

    // Reference mapping from the code-assignment rules: {valid, byte}.
    function automatic logic [8:0] ref_map(input bit up, input int c);
        if (c < 9)              return {1'b1, (up ? 8'hC1 : 8'h81) + 8'(c)};
        if (c >= 16 && c < 26)  return {1'b1, up ? UP_DIGIT[c-16] : 8'hF0 + 8'(c-16)};
        if (c == 62)            return {1'b1, 8'h15};
        if (c == 63)            return {1'b1, 8'h40};
        return 9'h000;
    endfunction

    vec_t vecs [14];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] q [$];
        bit         m_up, m_pend_v, m_ovr, m_inv;
        logic [7:0] m_pend_b;

        vecs = '{
            '{1'b0, 6'h00, 1'b0, 8'h81}, '{1'b1, 6'h00, 1'b0, 8'hC1},
            '{1'b0, 6'h10, 1'b0, 8'hF0}, '{1'b1, 6'h10, 1'b0, 8'h7E},
            '{1'b0, 6'h3F, 1'b0, 8'h40}, '{1'b1, 6'h3F, 1'b0, 8'h40},
            '{1'b0, 6'h3E, 1'b0, 8'h15}, '{1'b1, 6'h3E, 1'b0, 8'h15},
            '{1'b0, 6'h08, 1'b0, 8'h89}, '{1'b1, 6'h08, 1'b0, 8'hC9},
            '{1'b0, 6'h19, 1'b0, 8'hF9}, '{1'b0, 6'h2A, 1'b1, 8'h00},
            '{1'b0, 6'h09, 1'b1, 8'h00}, '{1'b1, 6'h3B, 1'b1, 8'h00}
        };

        bus.i_kbd_code    = '0;
        bus.i_kbd_strobe  = 1'b0;
        bus.i_rd          = 1'b0;
        bus.i_clr_overrun = 1'b0;
        tick();
        tick();
        chk("rst_valid", bus.o_data_valid, 1'b0);
        chk("rst_data", bus.o_data_reg, 8'h00);
        chk("rst_upper", bus.o_upper_case_character, 1'b0);
        chk("rst_lower", bus.o_lower_case_character, 1'b1);
        chk("rst_overrun", bus.o_overrun, 1'b0);
        chk("rst_invalid", bus.o_invalid, 1'b0);
`ifdef TT2E_PARITY_EN
        chk("rst_parity", bus.o_data_parity, 1'b1);
`endif
        rst = 1'b0;
        tick();

        // In-order delivery and two-cycle latency
        key(6'h10);
        chk("lat_not_yet", bus.o_data_valid, 1'b0);
        key(TT_NL);
        chk("lat_valid", bus.o_data_valid, 1'b1);
        key(TT_SP);
        tick();
        pop_expect("ord0", 8'hF0);
        pop_expect("ord1", 8'h15);
        pop_expect("ord2", 8'h40);
        chk("ord_empty", bus.o_data_valid, 1'b0);

        // Case shifting
        key(6'h00);
        chk("sh_low0", bus.o_upper_case_character, 1'b0);
        key(SHIFT_UP);
        chk("sh_up1", bus.o_upper_case_character, 1'b1);
        chk("sh_low1", bus.o_lower_case_character, 1'b0);
        key(6'h00);
        chk("sh_up2", bus.o_upper_case_character, 1'b1);
        key(SHIFT_DOWN);
        chk("sh_up3", bus.o_upper_case_character, 1'b0);
        chk("sh_low3", bus.o_lower_case_character, 1'b1);
        key(6'h00);
        tick();
        pop_expect("sh_a", 8'h81);
        pop_expect("sh_A", 8'hC1);
        pop_expect("sh_a2", 8'h81);

        // Table of single keys under a forced shift state
        for (int i = 0; i < 14; i++) begin
            key(vecs[i].up ? SHIFT_UP : SHIFT_DOWN);
            key(vecs[i].code);
            chk($sformatf("tab%0d_inv", i), bus.o_invalid, vecs[i].inv);
            tick();
            chk($sformatf("tab%0d_valid", i), bus.o_data_valid, !vecs[i].inv);
            if (!vecs[i].inv) pop_expect($sformatf("tab%0d", i), vecs[i].exp_byte);
        end
        key(SHIFT_DOWN);

        // Overflow: six keys into four slots
        for (int i = 0; i < 6; i++) key(6'(i));
        tick();
        chk("ovf_set", bus.o_overrun, 1'b1);
        bus.i_clr_overrun = 1'b1;
        tick();
        bus.i_clr_overrun = 1'b0;
        chk("ovf_clr", bus.o_overrun, 1'b0);
        for (int i = 0; i < 4; i++) pop_expect($sformatf("ovf%0d", i), 8'h81 + 8'(i));
        chk("ovf_empty", bus.o_data_valid, 1'b0);

        // Full FIFO with pop in the same cycle a write lands
        for (int i = 0; i < 4; i++) key(6'(i));
        tick();
        key(6'h04);
        bus.i_rd = 1'b1;
        tick();
        bus.i_rd = 1'b0;
        chk("fpp_noovr", bus.o_overrun, 1'b0);
        for (int i = 1; i < 5; i++) pop_expect($sformatf("fpp%0d", i), 8'h81 + 8'(i));
        chk("fpp_empty", bus.o_data_valid, 1'b0);

        // Unmapped code
        key(6'h2A);
        chk("inv_pulse", bus.o_invalid, 1'b1);
        tick();
        chk("inv_end", bus.o_invalid, 1'b0);
        chk("inv_nopush", bus.o_data_valid, 1'b0);

`ifdef TT2E_PARITY_EN
        key(SHIFT_UP);
        key(6'h00);
        key(SHIFT_DOWN);
        key(6'h00);
        tick();
        chk("par_C1", bus.o_data_parity, 1'b0);
        pop_expect("par0", 8'hC1);
        chk("par_81", bus.o_data_parity, 1'b1);
        pop_expect("par1", 8'h81);
`endif

        // Reset with three entries queued in upper case
        key(SHIFT_UP);
        key(6'h00);
        key(6'h01);
        key(6'h02);
        tick();
        chk("mr_pre_valid", bus.o_data_valid, 1'b1);
        chk("mr_pre_upper", bus.o_upper_case_character, 1'b1);
        rst = 1'b1;
        #1;
        chk("mr_valid", bus.o_data_valid, 1'b0);
        chk("mr_lower", bus.o_lower_case_character, 1'b1);
        chk("mr_upper", bus.o_upper_case_character, 1'b0);
        tick();
        rst = 1'b0;
        tick();
        chk("mr_after", bus.o_data_valid, 1'b0);

        // Random traffic against the queue model
        do_reset();
        q.delete();
        m_up = 0; m_pend_v = 0; m_ovr = 0; m_inv = 0; m_pend_b = '0;
        for (int cyc = 0; cyc < 1500; cyc++) begin
            bit         stb, rd, clr, pop, full, drop;
            int         c, sel;
            logic [8:0] r;
            sel = int'($urandom_range(0, 15));
            stb = ($urandom_range(0, 9) < 6);
            c   = (sel == 0) ? 60 : (sel == 1) ? 61 : int'($urandom_range(0, 63));
            rd  = ($urandom_range(0, 9) < 4);
            clr = ($urandom_range(0, 9) == 0);
            bus.i_kbd_code    = 6'(c);
            bus.i_kbd_strobe  = stb;
            bus.i_rd          = rd;
            bus.i_clr_overrun = clr;

            pop  = rd && (q.size() > 0);
            full = (q.size() == DEPTH);
            drop = 0;
            if (pop) void'(q.pop_front());
            if (m_pend_v) begin
                if (!full || pop) q.push_back(m_pend_b);
                else drop = 1;
            end
            m_ovr    = drop || (m_ovr && !clr);
            m_pend_v = 0;
            m_inv    = 0;
            if (stb) begin
                if (c == 60) m_up = 1;
                else if (c == 61) m_up = 0;
                else begin
                    r = ref_map(m_up, c);
                    m_pend_v = r[8];
                    m_pend_b = r[7:0];
                    m_inv    = !r[8];
                end
            end

            tick();
            chk("rnd_valid", bus.o_data_valid, q.size() > 0);
            if (q.size() > 0) chk("rnd_data", bus.o_data_reg, q[0]);
            chk("rnd_upper", bus.o_upper_case_character, m_up);
            chk("rnd_lower", bus.o_lower_case_character, !m_up);
            chk("rnd_overrun", bus.o_overrun, m_ovr);
            chk("rnd_invalid", bus.o_invalid, m_inv);
`ifdef TT2E_PARITY_EN
            chk("rnd_parity", bus.o_data_parity, (q.size() > 0) ? ~^q[0] : 1'b1);
`endif
        end
        bus.i_kbd_strobe  = 1'b0;
        bus.i_rd          = 1'b0;
        bus.i_clr_overrun = 1'b0;
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/tt2e.md
# tt2e

Keyboard-side converter for the 2150 console typewriter: accepts 6-bit tilt/rotate keyboard codes, tracks the case-shift state, translates each character key to an EBCDIC byte and buffers it in a small FIFO for the channel-side data register. It is the input-direction counterpart of the EBCDIC-to-tilt/rotate print path and shares its code assignments.

## Interface
- FIFO_AW, 2, log2 of FIFO depth (default 4 entries)
- i_clk  in  1  clock
- i_reset  in  1  asynchronous, active-high reset
- i_kbd_code  in  6  tilt/rotate code of key pressed, valid with strobe
- i_kbd_strobe  in  1  one-cycle pulse per key event
- i_rd  in  1  consumer pops FIFO head; ignored when o_data_valid=0
- i_clr_overrun  in  1  clears o_overrun
- o_data_reg  out  8  EBCDIC byte at FIFO head (first-word-fall-through)
- o_data_valid  out  1  FIFO non-empty
- o_upper_case_character  out  1  current shift state is upper
- o_lower_case_character  out  1  current shift state is lower (inverse of above)
- o_overrun  out  1  sticky: a character was dropped because FIFO was full
- o_invalid  out  1  one-cycle pulse: strobed code has no mapping
- o_data_parity  out  1  only with TT2E_PARITY_EN; odd parity of o_data_reg

## Operation
- Shift FSM, states LOWER (reset) and UPPER. Code 6'h3C (SHIFT_UP) -> UPPER; 6'h3D (SHIFT_DOWN) -> LOWER; shift codes are never pushed. Shift in already-held state: no change, no error.
- Character keys translated by case: 6'h00 -> 8'h81 (lower) / 8'hC1 (upper); 6'h10 -> 8'hF0 / 8'h7E; 6'h3F (space) -> 8'h40 both cases; 6'h3E (NL) -> 8'h15 both cases. Full map lives in the package; unmapped codes pulse o_invalid and push nothing.
- Translation uses the shift state in effect before the strobe; a shift code and a character cannot arrive in the same cycle (one strobe carries one code).
- FIFO: write when translated byte ready and not full; full write drops byte and sets o_overrun. Push and pop in same cycle when full: pop frees slot, write accepted, no overrun. Pop when empty: ignored.
- o_overrun cleared by i_clr_overrun; set and clear same cycle -> stays set.
- Pointers wrap modulo 2**FIFO_AW; count width FIFO_AW+1 distinguishes full from empty.
- Reset at any time: FIFO flushed, in-flight translation discarded, state LOWER.

## Timing
- Reset values: o_data_reg=0, o_data_valid=0, o_upper_case_character=0, o_lower_case_character=1, o_overrun=0, o_invalid=0, o_data_parity=1 (odd parity of 0).
- Strobe in cycle N: translation registered at N+1 (o_invalid pulses at N+1); FIFO write at N+1 edge; o_data_valid/o_data_reg visible at N+2 when FIFO was empty.
- Shift code in cycle N: case outputs change at N+1; character strobed at N+1 or later uses new state.
- i_rd in cycle M with valid: next entry (or valid=0) at M+1.
- Back-to-back strobes every cycle sustained; throughput 1 char/cycle.

## Configuration
- TT2E_PARITY_EN defined: FIFO entries 9 bits, odd parity computed at translation, port o_data_parity present.
- Undefined: 8-bit entries, o_data_parity absent; all other behaviour identical.

## Structure
- Package tt2e_pkg: tilt/rotate constants (SHIFT_UP, SHIFT_DOWN, TT_SP, TT_NL), EBCDIC constants (E_NL, E_SP, E_A, E_a, E_0), shift-state enum, translate function returning {valid, byte} from {case, code}.
- One sub-module: tt2e_fifo (parameterised FWFT FIFO with full/empty, simultaneous push/pop).

## Test plan
- Reset, then strobe 6'h10, 6'h3E, 6'h3F -> bytes F0, 15, 40 in order; first valid two cycles after first strobe.
- Strobe 6'h00; SHIFT_UP; 6'h00; SHIFT_DOWN; 6'h00 -> 81, C1, 81; upper flag high exactly between shift codes.
- Six character strobes, no reads, FIFO_AW=2 -> four bytes held, o_overrun=1; i_clr_overrun clears it; reads return first four in order.
- FIFO full, i_rd in the same cycle as a write landing -> no overrun, ordering preserved.
- Strobe unmapped code 6'h2A -> o_invalid one cycle, FIFO unchanged.
- Assert i_reset with 3 entries queued and state UPPER -> valid=0, lower flag=1 immediately; with TT2E_PARITY_EN, byte C1 gives o_data_parity=0, 81 gives 1.
